// File: rtl/ahblite_master_arbiter_if.sv
// AHB-Lite address/control, write data and response signals for one bus segment.
// The master modport is the side that issues transfers; slave is the side that answers.
interface ahblite_master_arbiter_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        output HREADY, HRDATA, HRESP
    );
endinterface

// File: rtl/ahblite_master_arbiter.sv
// Two-master AHB-Lite arbiter: losing address phases are parked in a holding register
// and replayed once granted; fixed bursts and locked sequences keep the grant.
module ahblite_master_arbiter #(
    parameter bit ARB_MODE = 1'b0
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    ahblite_master_arbiter_if.slave       m0,
    ahblite_master_arbiter_if.slave       m1,
    ahblite_master_arbiter_if.master      s,
    output logic                          HMASTER
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_SINGLE = 3'b000;
    localparam logic [2:0] BU_INCR   = 3'b001;

    typedef struct packed {
        logic [31:0] haddr;
        logic [2:0]  hburst;
        logic        hmastlock;
        logic [3:0]  hprot;
        logic [2:0]  hsize;
        logic [1:0]  htrans;
        logic        hwrite;
    } ahb_ctl_t;

    logic       g;
    logic [1:0] pend;
    logic       dvld;
    logic       dsel;
    logic [3:0] cnt;
    ahb_ctl_t   held [2];

    ahb_ctl_t   live [2];
    ahb_ctl_t   fwd;
    logic [1:0] m_hready;
    logic [1:0] capture;
    logic [1:0] req;
    logic [1:0] pend_next;
    logic       accept;
    logic       fixed_burst;
    logic       release_pt;
    logic       g_next;
    logic [3:0] burst_last;

    always_comb begin
        live[0].haddr     = m0.HADDR;
        live[0].hburst    = m0.HBURST;
        live[0].hmastlock = m0.HMASTLOCK;
        live[0].hprot     = m0.HPROT;
        live[0].hsize     = m0.HSIZE;
        live[0].htrans    = m0.HTRANS;
        live[0].hwrite    = m0.HWRITE;
        live[1].haddr     = m1.HADDR;
        live[1].hburst    = m1.HBURST;
        live[1].hmastlock = m1.HMASTLOCK;
        live[1].hprot     = m1.HPROT;
        live[1].hsize     = m1.HSIZE;
        live[1].htrans    = m1.HTRANS;
        live[1].hwrite    = m1.HWRITE;
    end

    // The granted master issues from its holding register while a captured transfer waits.
    always_comb begin
        fwd = pend[g] ? held[g] : live[g];
        if (HRESET) fwd = '0;
    end

    // A master sees the slave's HREADY only while it owns the data phase.
    always_comb begin
        m_hready[0] = (dvld && !dsel) ? s.HREADY : !pend[0];
        m_hready[1] = (dvld &&  dsel) ? s.HREADY : !pend[1];
        capture[0]  = m_hready[0] && live[0].htrans[1] && !(!g && s.HREADY);
        capture[1]  = m_hready[1] && live[1].htrans[1] && !( g && s.HREADY);
        req[0]      = pend[0] | live[0].htrans[1];
        req[1]      = pend[1] | live[1].htrans[1];
    end

    always_comb begin
        accept      = s.HREADY && fwd.htrans[1];
        fixed_burst = (fwd.hburst != BU_SINGLE) && (fwd.hburst != BU_INCR);
        release_pt  = s.HREADY && !fwd.hmastlock &&
                      ((fwd.htrans == TR_IDLE) ||
                       (accept && fwd.htrans == TR_NONSEQ && fwd.hburst == BU_SINGLE) ||
                       (accept && fwd.htrans == TR_SEQ && cnt == 4'd1 && fixed_burst));

        g_next = g;
        if (release_pt) begin
            case (req)
                2'b01:   g_next = 1'b0;
                2'b10:   g_next = 1'b1;
                2'b11:   g_next = ARB_MODE ? ~g : 1'b0;
                default: g_next = g;
            endcase
        end

        case (fwd.hburst)
            3'b010, 3'b011: burst_last = 4'd3;
            3'b100, 3'b101: burst_last = 4'd7;
            3'b110, 3'b111: burst_last = 4'd15;
            default:        burst_last = 4'd0;
        endcase

        pend_next = pend;
        if (accept)     pend_next[g] = 1'b0;
        if (capture[0]) pend_next[0] = 1'b1;
        if (capture[1]) pend_next[1] = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            g    <= 1'b0;
            pend <= 2'b00;
            dvld <= 1'b0;
            dsel <= 1'b0;
            cnt  <= 4'd0;
        end else begin
            g    <= g_next;
            pend <= pend_next;
            if (s.HREADY) begin
                if (accept) begin
                    dvld <= 1'b1;
                    dsel <= g;
                    cnt  <= (fwd.htrans == TR_NONSEQ) ? burst_last : cnt - 4'd1;
                end else begin
                    dvld <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (capture[0]) held[0] <= live[0];
        if (capture[1]) held[1] <= live[1];
    end

    assign s.HADDR     = fwd.haddr;
    assign s.HBURST    = fwd.hburst;
    assign s.HMASTLOCK = fwd.hmastlock;
    assign s.HPROT     = fwd.hprot;
    assign s.HSIZE     = fwd.hsize;
    assign s.HTRANS    = fwd.htrans;
    assign s.HWRITE    = fwd.hwrite;
    assign s.HWDATA    = HRESET ? 32'h0 : (dsel ? m1.HWDATA : m0.HWDATA);

    assign m0.HREADY = m_hready[0];
    assign m1.HREADY = m_hready[1];
    assign m0.HRDATA = (dvld && !dsel) ? s.HRDATA : 32'h0;
    assign m1.HRDATA = (dvld &&  dsel) ? s.HRDATA : 32'h0;
    assign m0.HRESP  = dvld && !dsel && s.HRESP;
    assign m1.HRESP  = dvld &&  dsel && s.HRESP;

    assign HMASTER = g;

endmodule

// File: tb/tb_ahblite_master_arbiter.sv
// Directed bench for ahblite_master_arbiter: fixed-priority instance for most steps,
// a round-robin instance sharing the same stimulus for the alternation step.
module tb_ahblite_master_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR4  = 3'b011;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    logic hmaster0;
    logic hmaster1;
    int   tests = 0;
    int   fails = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_v;

    ahblite_master_arbiter_if m0 ();
    ahblite_master_arbiter_if m1 ();
    ahblite_master_arbiter_if s ();
    ahblite_master_arbiter_if rm0 ();
    ahblite_master_arbiter_if rm1 ();
    ahblite_master_arbiter_if rs ();

    // clock / reset
    always #5 HCLK = ~HCLK;

    ahblite_master_arbiter #(.ARB_MODE(1'b0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .m0(m0), .m1(m1), .s(s), .HMASTER(hmaster0)
    );

    ahblite_master_arbiter #(.ARB_MODE(1'b1)) dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .m0(rm0), .m1(rm1), .s(rs), .HMASTER(hmaster1)
    );

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive_m0(input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] ad,
                            input logic wr, input logic lk);
        m0.HTRANS = tr;  m0.HBURST = bu;  m0.HADDR = ad;  m0.HWRITE = wr;  m0.HMASTLOCK = lk;
        m0.HPROT = 4'h3; m0.HSIZE = 3'b010;
        rm0.HTRANS = tr; rm0.HBURST = bu; rm0.HADDR = ad; rm0.HWRITE = wr; rm0.HMASTLOCK = lk;
        rm0.HPROT = 4'h3; rm0.HSIZE = 3'b010;
    endtask

    task automatic drive_m1(input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] ad,
                            input logic wr, input logic lk);
        m1.HTRANS = tr;  m1.HBURST = bu;  m1.HADDR = ad;  m1.HWRITE = wr;  m1.HMASTLOCK = lk;
        m1.HPROT = 4'h1; m1.HSIZE = 3'b010;
        rm1.HTRANS = tr; rm1.HBURST = bu; rm1.HADDR = ad; rm1.HWRITE = wr; rm1.HMASTLOCK = lk;
        rm1.HPROT = 4'h1; rm1.HSIZE = 3'b010;
    endtask

    task automatic wdata(input logic [31:0] w0, input logic [31:0] w1);
        m0.HWDATA = w0; rm0.HWDATA = w0;
        m1.HWDATA = w1; rm1.HWDATA = w1;
    endtask

    task automatic drive_s(input logic rdy, input logic [31:0] rd, input logic rsp);
        s.HREADY = rdy;  s.HRDATA = rd;  s.HRESP = rsp;
        rs.HREADY = rdy; rs.HRDATA = rd; rs.HRESP = rsp;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    logic [31:0] rr_a0 [5] = '{32'hA00, 32'hA04, 32'hA08, 32'hA08, 32'hA0C};
    logic [31:0] rr_a1 [5] = '{32'hB00, 32'hB04, 32'hB04, 32'hB08, 32'hB08};

    initial begin
        drive_m0(NONSEQ, SINGLE, 32'hFFFF_0000, 1'b1, 1'b0);
        drive_m1(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        wdata(32'hAAAA_AAAA, 32'h0);
        drive_s(1'b1, 32'h0, 1'b0);
        HRESET = 1'b1;
        tick();
        tick();
        #2;
        check("rst_htrans", s.HTRANS, IDLE);
        check("rst_haddr", s.HADDR, 32'h0);
        check("rst_hwdata", s.HWDATA, 32'h0);
        check("rst_hmaster", hmaster0, 1'b0);
        check("rst_m0_hready", m0.HREADY, 1'b1);
        check("rst_m1_hready", m1.HREADY, 1'b1);
        check("rst_m0_hrdata", m0.HRDATA, 32'h0);
        check("rst_m1_hresp", m1.HRESP, 1'b0);
        tick();
        HRESET = 1'b0;
        drive_m0(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        wdata(32'h0, 32'h0);
        tick();

        // single master, zero wait states
        drive_m0(NONSEQ, SINGLE, 32'h10, 1'b0, 1'b0);
        #2;
        check("a1_htrans", s.HTRANS, NONSEQ);
        check("a1_haddr", s.HADDR, 32'h10);
        check("a1_hprot", s.HPROT, 4'h3);
        check("a1_hmaster", hmaster0, 1'b0);
        check("a1_m0_hready", m0.HREADY, 1'b1);
        tick();
        drive_s(1'b1, 32'hA0A0_0001, 1'b0);
        #2;
        check("a2_haddr", s.HADDR, 32'h10);
        check("a2_m0_hrdata", m0.HRDATA, 32'hA0A0_0001);
        check("a2_m1_hrdata", m1.HRDATA, 32'h0);
        check("a2_m0_hready", m0.HREADY, 1'b1);
        tick();
        drive_m0(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        drive_s(1'b1, 32'hA0A0_0002, 1'b0);
        #2;
        check("a3_m0_hrdata", m0.HRDATA, 32'hA0A0_0002);
        check("a3_m0_hready", m0.HREADY, 1'b1);
        tick();
        drive_s(1'b1, 32'h55, 1'b0);
        #2;
        check("a4_m0_hrdata_idle", m0.HRDATA, 32'h0);
        tick();

        // contention, fixed priority
        drive_s(1'b1, 32'h0, 1'b0);
        drive_m0(NONSEQ, SINGLE, 32'h100, 1'b1, 1'b0);
        drive_m1(NONSEQ, SINGLE, 32'h200, 1'b1, 1'b0);
        #2;
        check("b1_haddr", s.HADDR, 32'h100);
        check("b1_hmaster", hmaster0, 1'b0);
        check("b1_m1_hready", m1.HREADY, 1'b1);
        tick();
        drive_m0(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        drive_m1(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        wdata(32'h1111_0000, 32'h2222_0000);
        #2;
        check("b2_hwdata_m0", s.HWDATA, 32'h1111_0000);
        check("b2_m1_hready", m1.HREADY, 1'b0);
        check("b2_htrans", s.HTRANS, IDLE);
        tick();
        #2;
        check("b3_hmaster", hmaster0, 1'b1);
        check("b3_haddr_held", s.HADDR, 32'h200);
        check("b3_htrans", s.HTRANS, NONSEQ);
        check("b3_hwrite", s.HWRITE, 1'b1);
        check("b3_m1_hready", m1.HREADY, 1'b0);
        tick();
        #2;
        check("b4_hwdata_m1", s.HWDATA, 32'h2222_0000);
        check("b4_m1_hready", m1.HREADY, 1'b1);
        tick();
        wdata(32'h0, 32'h0);
        #2;
        check("b5_parked", hmaster0, 1'b1);
        tick();

        // INCR4 from M1 holds the grant against M0
        drive_m1(NONSEQ, INCR4, 32'h300, 1'b1, 1'b0);
        #2;
        check("c1_haddr", s.HADDR, 32'h300);
        check("c1_hburst", s.HBURST, INCR4);
        check("c1_m1_hready", m1.HREADY, 1'b1);
        tick();
        drive_m1(SEQ, INCR4, 32'h304, 1'b1, 1'b0);
        drive_m0(NONSEQ, SINGLE, 32'h400, 1'b0, 1'b0);
        wdata(32'h0, 32'h30);
        #2;
        check("c2_cnt", dut0.cnt, 4'd3);
        check("c2_haddr", s.HADDR, 32'h304);
        tick();
        drive_m1(SEQ, INCR4, 32'h308, 1'b1, 1'b0);
        drive_m0(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        #2;
        check("c3_cnt", dut0.cnt, 4'd2);
        check("c3_m0_hready", m0.HREADY, 1'b0);
        check("c3_hmaster", hmaster0, 1'b1);
        tick();
        drive_m1(SEQ, INCR4, 32'h30C, 1'b1, 1'b0);
        #2;
        check("c4_cnt", dut0.cnt, 4'd1);
        check("c4_hmaster", hmaster0, 1'b1);
        check("c4_haddr", s.HADDR, 32'h30C);
        tick();
        drive_m1(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        #2;
        check("c5_hmaster", hmaster0, 1'b0);
        check("c5_haddr_held", s.HADDR, 32'h400);
        check("c5_cnt", dut0.cnt, 4'd0);
        check("c5_m0_hready", m0.HREADY, 1'b0);
        check("c5_m1_hready", m1.HREADY, 1'b1);
        tick();
        drive_s(1'b1, 32'hC0DE_0400, 1'b0);
        #2;
        check("c6_m0_hrdata", m0.HRDATA, 32'hC0DE_0400);
        check("c6_m1_hrdata", m1.HRDATA, 32'h0);
        check("c6_m0_hready", m0.HREADY, 1'b1);
        tick();

        // locked sequence with a two-cycle ERROR on M0
        drive_s(1'b1, 32'h0, 1'b0);
        drive_m0(NONSEQ, SINGLE, 32'h500, 1'b0, 1'b1);
        drive_m1(NONSEQ, SINGLE, 32'h600, 1'b0, 1'b0);
        #2;
        check("d1_hmastlock", s.HMASTLOCK, 1'b1);
        check("d1_haddr", s.HADDR, 32'h500);
        tick();
        drive_m0(NONSEQ, SINGLE, 32'h504, 1'b0, 1'b1);
        drive_m1(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        #2;
        check("d2_m1_hready", m1.HREADY, 1'b0);
        tick();
        drive_m0(NONSEQ, SINGLE, 32'h508, 1'b0, 1'b1);
        drive_s(1'b0, 32'h0, 1'b1);
        #2;
        check("d3_m0_hresp", m0.HRESP, 1'b1);
        check("d3_m0_hready", m0.HREADY, 1'b0);
        check("d3_m1_hresp", m1.HRESP, 1'b0);
        check("d3_m1_hready", m1.HREADY, 1'b0);
        tick();
        drive_s(1'b1, 32'h0, 1'b1);
        #2;
        check("d4_m0_hresp", m0.HRESP, 1'b1);
        check("d4_m0_hready", m0.HREADY, 1'b1);
        check("d4_m1_hresp", m1.HRESP, 1'b0);
        check("d4_hmaster", hmaster0, 1'b0);
        tick();
        drive_m0(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        drive_s(1'b1, 32'h0, 1'b0);
        #2;
        check("d5_m1_hready", m1.HREADY, 1'b0);
        check("d5_hmaster", hmaster0, 1'b0);
        tick();
        #2;
        check("d6_hmaster", hmaster0, 1'b1);
        check("d6_haddr_held", s.HADDR, 32'h600);
        check("d6_m1_hready", m1.HREADY, 1'b0);
        tick();
        drive_s(1'b1, 32'h6666, 1'b0);
        #2;
        check("d7_m1_hrdata", m1.HRDATA, 32'h6666);
        check("d7_m0_hrdata", m0.HRDATA, 32'h0);
        tick();

        // reset while M1 is held and the slave stalls
        drive_s(1'b1, 32'h0, 1'b0);
        drive_m0(NONSEQ, SINGLE, 32'h800, 1'b0, 1'b0);
        drive_m1(NONSEQ, SINGLE, 32'h700, 1'b0, 1'b0);
        #2;
        check("e1_hmaster", hmaster0, 1'b1);
        check("e1_haddr", s.HADDR, 32'h700);
        tick();
        drive_m0(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        drive_m1(NONSEQ, SINGLE, 32'h704, 1'b0, 1'b0);
        #2;
        check("e2_hmaster", hmaster0, 1'b0);
        check("e2_haddr_held", s.HADDR, 32'h800);
        tick();
        drive_m1(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        drive_s(1'b0, 32'h0, 1'b0);
        #2;
        check("e3_m1_hready", m1.HREADY, 1'b0);
        check("e3_m0_hready", m0.HREADY, 1'b0);
        HRESET = 1'b1;
        tick();
        drive_m0(NONSEQ, SINGLE, 32'h900, 1'b1, 1'b0);
        wdata(32'h1234, 32'h5678);
        drive_s(1'b0, 32'hDEAD, 1'b1);
        #2;
        check("e4_htrans", s.HTRANS, IDLE);
        check("e4_haddr", s.HADDR, 32'h0);
        check("e4_hwdata", s.HWDATA, 32'h0);
        check("e4_hmaster", hmaster0, 1'b0);
        check("e4_m0_hready", m0.HREADY, 1'b1);
        check("e4_m1_hready", m1.HREADY, 1'b1);
        check("e4_m0_hrdata", m0.HRDATA, 32'h0);
        check("e4_m0_hresp", m0.HRESP, 1'b0);
        check("e4_m1_hresp", m1.HRESP, 1'b0);
        tick();
        HRESET = 1'b0;
        drive_m0(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        drive_m1(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        wdata(32'h0, 32'h0);
        drive_s(1'b1, 32'h0, 1'b0);
        tick();

        // round-robin instance: both masters request continuously
        exp_q.push_back({1'b0, 32'hA00});
        exp_q.push_back({1'b1, 32'hB00});
        exp_q.push_back({1'b0, 32'hA04});
        exp_q.push_back({1'b1, 32'hB04});
        exp_q.push_back({1'b0, 32'hA08});
        for (int k = 0; k < 5; k++) begin
            drive_m0(NONSEQ, SINGLE, rr_a0[k], 1'b0, 1'b0);
            drive_m1(NONSEQ, SINGLE, rr_a1[k], 1'b0, 1'b0);
            #2;
            exp_v = exp_q.pop_front();
            check("rr_grant_addr", {hmaster1, rs.HADDR}, exp_v);
            tick();
        end
        drive_m0(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        drive_m1(IDLE, SINGLE, 32'h0, 1'b0, 1'b0);
        tick();
        tick();

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
